// File: rtl/spi_reg_if.sv
// Bus between the SPI byte deserializer / register bank and the command controller.
// The controller uses the slave modport; the environment side uses master.
interface spi_reg_if;
  logic       CS;
  logic       rx_valid;
  logic [7:0] rx_byte;
  logic [7:0] tx_byte;
  logic       tx_load;
  logic [6:0] reg_addr;
  logic [7:0] reg_wdata;
  logic       reg_we;
  logic       reg_re;
  logic [7:0] reg_rdata;
  logic [7:0] byte_cnt;
  logic       err;

  modport slave (
    input  CS, rx_valid, rx_byte, reg_rdata,
    output tx_byte, tx_load, reg_addr, reg_wdata, reg_we, reg_re, byte_cnt, err
  );

  modport master (
    output CS, rx_valid, rx_byte, reg_rdata,
    input  tx_byte, tx_load, reg_addr, reg_wdata, reg_we, reg_re, byte_cnt, err
  );
endinterface

// File: rtl/spi_reg_ctrl.sv
// SPI command/register controller: decodes the first byte of each CS frame as a
// command and sequences burst writes or prefetched reads against the register bank.
module spi_reg_ctrl #(
  parameter int         NUM_REGS = 16,
  parameter bit         AUTO_INC = 1'b1,
  parameter logic [7:0] ERR_BYTE = 8'hFF
) (
  input  logic      clk,
  input  logic      rst,
  spi_reg_if.slave  bus
);

  localparam logic [7:0] NREG8     = 8'(NUM_REGS);
  localparam logic [6:0] LAST_ADDR = 7'(NUM_REGS - 1);

  typedef enum logic [2:0] {
    IDLE    = 3'd0,
    WRITE   = 3'd1,
    FETCH   = 3'd2,
    READ    = 3'd3,
    DISCARD = 3'd4
  } state_t;

  state_t     state, state_nxt;

  logic [7:0] tx_byte_q, tx_byte_d;
  logic       tx_load_q, tx_load_d;
  logic [6:0] addr_q, addr_d;
  logic [7:0] wdata_q, wdata_d;
  logic       we_q, we_d;
  logic       re_q, re_d;
  logic [7:0] cnt_q, cnt_d;
  logic       err_q, err_d;

  logic       cmd_bad;

  function automatic logic [6:0] addr_adv(input logic [6:0] a);
    if (!AUTO_INC)
      return a;
    if (a == LAST_ADDR)
      return 7'd0;
    return a + 7'd1;
  endfunction

  function automatic logic [7:0] sat_inc(input logic [7:0] c);
    return (c == 8'hFF) ? c : c + 8'd1;
  endfunction

  assign cmd_bad = ({1'b0, bus.rx_byte[6:0]} >= NREG8);

  always_ff @(posedge clk) begin
    if (rst)
      state <= IDLE;
    else
      state <= state_nxt;
  end

  // FETCH spends its first cycle with reg_re high; the bank answers on the next.
  always_comb begin
    state_nxt = state;
    if (bus.CS) begin
      state_nxt = IDLE;
    end else begin
      case (state)
        IDLE: begin
          if (bus.rx_valid) begin
            if (cmd_bad)
              state_nxt = DISCARD;
            else if (bus.rx_byte[7])
              state_nxt = FETCH;
            else
              state_nxt = WRITE;
          end
        end
        WRITE:   state_nxt = WRITE;
        FETCH:   if (!re_q) state_nxt = READ;
        READ:    if (bus.rx_valid) state_nxt = FETCH;
        DISCARD: state_nxt = DISCARD;
        default: state_nxt = IDLE;
      endcase
    end
  end

  always_comb begin
    tx_byte_d = tx_byte_q;
    tx_load_d = 1'b0;
    addr_d    = addr_q;
    wdata_d   = wdata_q;
    we_d      = 1'b0;
    re_d      = 1'b0;
    err_d     = 1'b0;
    cnt_d     = cnt_q;
    if (bus.CS) begin
      cnt_d = 8'd0;
    end else begin
      if (bus.rx_valid)
        cnt_d = sat_inc(cnt_q);
      case (state)
        IDLE: begin
          if (bus.rx_valid) begin
            addr_d = bus.rx_byte[6:0];
            if (cmd_bad) begin
              err_d     = 1'b1;
              tx_byte_d = ERR_BYTE;
              tx_load_d = 1'b1;
            end else if (bus.rx_byte[7]) begin
              re_d = 1'b1;
            end
          end
        end
        WRITE: begin
          // Advance one cycle after the strobe so the write used the old address.
          if (we_q)
            addr_d = addr_adv(addr_q);
          if (bus.rx_valid) begin
            we_d    = 1'b1;
            wdata_d = bus.rx_byte;
          end
        end
        FETCH: begin
          if (bus.rx_valid)
            err_d = 1'b1;
          if (!re_q) begin
            tx_byte_d = bus.reg_rdata;
            tx_load_d = 1'b1;
          end
        end
        READ: begin
          if (bus.rx_valid) begin
            addr_d = addr_adv(addr_q);
            re_d   = 1'b1;
          end
        end
        DISCARD: begin
          if (bus.rx_valid) begin
            tx_byte_d = ERR_BYTE;
            tx_load_d = 1'b1;
          end
        end
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      tx_byte_q <= 8'h00;
      tx_load_q <= 1'b0;
      addr_q    <= 7'd0;
      wdata_q   <= 8'h00;
      we_q      <= 1'b0;
      re_q      <= 1'b0;
      cnt_q     <= 8'd0;
      err_q     <= 1'b0;
    end else begin
      tx_byte_q <= tx_byte_d;
      tx_load_q <= tx_load_d;
      addr_q    <= addr_d;
      wdata_q   <= wdata_d;
      we_q      <= we_d;
      re_q      <= re_d;
      cnt_q     <= cnt_d;
      err_q     <= err_d;
    end
  end

  assign bus.tx_byte   = tx_byte_q;
  assign bus.tx_load   = tx_load_q;
  assign bus.reg_addr  = addr_q;
  assign bus.reg_wdata = wdata_q;
  assign bus.reg_we    = we_q;
  assign bus.reg_re    = re_q;
  assign bus.byte_cnt  = cnt_q;
  assign bus.err       = err_q;

endmodule

// File: tb/tb_spi_reg_ctrl.sv
// Scoreboard bench for spi_reg_ctrl: a frame-level model queues expected bus events,
// a negedge monitor pops and compares them as the controller produces them.
module tb_spi_reg_ctrl;
  localparam int         NUM_REGS = 16;
  localparam bit         AUTO_INC = 1'b1;
  localparam logic [7:0] ERR_BYTE = 8'hFF;

  typedef logic [7:0] bq_t [$];
  typedef struct packed {
    logic       we;
    logic       re;
    logic       ld;
    logic       er;
    logic [6:0] addr;
    logic [7:0] data;
  } ev_t;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   checks = 0;
  int   failures = 0;
  ev_t  exp_q [$];
  logic [7:0] mem     [0:127] = '{default: 8'h00};
  logic [7:0] ref_mem [0:127] = '{default: 8'h00};

  spi_reg_if bus ();

  spi_reg_ctrl #(.NUM_REGS(NUM_REGS), .AUTO_INC(AUTO_INC), .ERR_BYTE(ERR_BYTE)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus.slave)
  );

  always #5 clk = ~clk;

  // Register bank: synchronous write, read data valid the cycle after reg_re.
  always @(posedge clk) begin
    if (bus.reg_we) mem[bus.reg_addr] <= bus.reg_wdata;
    if (bus.reg_re) bus.reg_rdata <= mem[bus.reg_addr];
  end

  function automatic void chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h expected=%0h at %0t", name, act, exp, $time);
    end
  endfunction

  function automatic int next_addr(input int a);
    return AUTO_INC ? (a + 1) % NUM_REGS : a;
  endfunction

  function automatic ev_t mk(input logic we, re, ld, er, input int a, input logic [7:0] d);
    ev_t e;
    e.we = we; e.re = re; e.ld = ld; e.er = er; e.addr = 7'(a); e.data = d;
    return e;
  endfunction

  // Reference model: expected events for one complete frame.
  function automatic void model_frame(input bq_t b);
    int a;
    if (b.size() == 0) return;
    a = int'(b[0][6:0]);
    if (a >= NUM_REGS) begin
      exp_q.push_back(mk(0, 0, 1, 1, 0, ERR_BYTE));
      for (int i = 1; i < b.size(); i++) exp_q.push_back(mk(0, 0, 1, 0, 0, ERR_BYTE));
    end else if (!b[0][7]) begin
      for (int i = 1; i < b.size(); i++) begin
        exp_q.push_back(mk(1, 0, 0, 0, a, b[i]));
        ref_mem[a] = b[i];
        a = next_addr(a);
      end
    end else begin
      exp_q.push_back(mk(0, 1, 0, 0, a, 8'h00));
      exp_q.push_back(mk(0, 0, 1, 0, 0, ref_mem[a]));
      for (int i = 1; i < b.size(); i++) begin
        a = next_addr(a);
        exp_q.push_back(mk(0, 1, 0, 0, a, 8'h00));
        exp_q.push_back(mk(0, 0, 1, 0, 0, ref_mem[a]));
      end
    end
  endfunction

  always @(negedge clk) begin
    ev_t e;
    logic [7:0] act_d;
    if (bus.reg_we | bus.reg_re | bus.tx_load | bus.err) begin
      if (bus.reg_we & bus.reg_re) chk("we_re_exclusive", 32'(bus.reg_re), 32'h0);
      if (exp_q.size() == 0) begin
        checks++;
        failures++;
        $display("FAIL unexpected_event actual we=%0b re=%0b ld=%0b err=%0b required none at %0t",
                 bus.reg_we, bus.reg_re, bus.tx_load, bus.err, $time);
      end else begin
        e = exp_q.pop_front();
        chk("ev_flags", 32'({bus.reg_we, bus.reg_re, bus.tx_load, bus.err}),
            32'({e.we, e.re, e.ld, e.er}));
        if (e.we | e.re) chk("ev_addr", 32'(bus.reg_addr), 32'(e.addr));
        act_d = bus.reg_we ? bus.reg_wdata : bus.tx_byte;
        if (e.we | e.ld) chk("ev_data", 32'(act_d), 32'(e.data));
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check_reset_outputs(input string tag);
    chk({tag, "_tx_byte"}, 32'(bus.tx_byte), 32'h0);
    chk({tag, "_tx_load"}, 32'(bus.tx_load), 32'h0);
    chk({tag, "_reg_addr"}, 32'(bus.reg_addr), 32'h0);
    chk({tag, "_reg_wdata"}, 32'(bus.reg_wdata), 32'h0);
    chk({tag, "_we_re_err"}, 32'({bus.reg_we, bus.reg_re, bus.err}), 32'h0);
    chk({tag, "_byte_cnt"}, 32'(bus.byte_cnt), 32'h0);
  endtask

  task automatic send_frame(input bq_t b, input int gap);
    model_frame(b);
    bus.CS = 1'b0;
    tick();
    tick();
    for (int i = 0; i < b.size(); i++) begin
      bus.rx_byte  = b[i];
      bus.rx_valid = 1'b1;
      tick();
      bus.rx_valid = 1'b0;
      repeat (gap - 1) tick();
    end
    repeat (4) tick();
    chk("byte_cnt_frame", 32'(bus.byte_cnt), (b.size() > 255) ? 32'd255 : 32'(b.size()));
    bus.CS = 1'b1;
    tick();
    chk("byte_cnt_cs_clear", 32'(bus.byte_cnt), 32'h0);
    tick();
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    bq_t f;
    bus.CS        = 1'b1;
    bus.rx_valid  = 1'b0;
    bus.rx_byte   = 8'h00;
    rst = 1'b1;
    repeat (3) tick();
    check_reset_outputs("reset");
    rst = 1'b0;
    tick();

    send_frame('{8'h03, 8'hA5, 8'h5A}, 16);
    send_frame('{8'h02, 8'h11, 8'h22}, 16);
    send_frame('{8'h82, 8'h00}, 16);
    send_frame('{8'h0F, 8'hAA, 8'hBB}, 16);
    send_frame('{8'h8F, 8'h00, 8'h00}, 18);
    send_frame('{8'h90, 8'h01, 8'h02}, 16);

    // Abort: CS rises together with a data byte in WRITE; the byte must be dropped.
    send_frame('{8'h05, 8'h77}, 16);
    bus.CS = 1'b0;
    tick();
    bus.rx_byte = 8'h05;
    bus.rx_valid = 1'b1;
    tick();
    bus.rx_valid = 1'b0;
    repeat (16) tick();
    bus.rx_byte = 8'h99;
    bus.rx_valid = 1'b1;
    bus.CS = 1'b1;
    tick();
    bus.rx_valid = 1'b0;
    chk("abort_byte_cnt", 32'(bus.byte_cnt), 32'h0);
    repeat (4) tick();
    send_frame('{8'h85, 8'h00}, 16);

    // A byte arriving during FETCH flags err but the read still completes.
    exp_q.push_back(mk(0, 1, 0, 0, 3, 8'h00));
    exp_q.push_back(mk(0, 0, 0, 1, 0, 8'h00));
    exp_q.push_back(mk(0, 0, 1, 0, 0, ref_mem[3]));
    bus.CS = 1'b0;
    tick();
    bus.rx_byte = 8'h83;
    bus.rx_valid = 1'b1;
    tick();
    bus.rx_byte = 8'h00;
    tick();
    bus.rx_valid = 1'b0;
    repeat (20) tick();
    chk("fetch_collision_cnt", 32'(bus.byte_cnt), 32'd2);
    bus.CS = 1'b1;
    repeat (2) tick();

    // Reset while FETCH is waiting for read data: no tx_load may follow.
    exp_q.push_back(mk(0, 1, 0, 0, 2, 8'h00));
    bus.CS = 1'b0;
    tick();
    bus.rx_byte = 8'h82;
    bus.rx_valid = 1'b1;
    tick();
    bus.rx_valid = 1'b0;
    rst = 1'b1;
    tick();
    check_reset_outputs("midread_reset");
    bus.CS = 1'b1;
    tick();
    rst = 1'b0;
    repeat (4) tick();

    // byte_cnt saturation inside a long discarded frame.
    f.delete();
    f.push_back(8'hFF);
    for (int i = 0; i < 259; i++) f.push_back(8'(i));
    send_frame(f, 2);

    for (int n = 0; n < 30; n++) begin
      f.delete();
      f.push_back({1'($urandom_range(0, 1)), 7'($urandom_range(0, NUM_REGS + 3))});
      for (int i = 0; i < int'($urandom_range(0, 4)); i++) f.push_back(8'($urandom));
      send_frame(f, 16 + int'($urandom_range(0, 4)));
    end

    for (int i = 0; i < 50 && exp_q.size() != 0; i++) tick();
    chk("scoreboard_drained", 32'(exp_q.size()), 32'h0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
